// File: rtl/alu_pkg.sv
// alu_pkg: shared op encoding, ALUOp codes and FSM state type for the ALU execute stage
package alu_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_XOR  = 3'b001,
    OP_SLL  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_MUL  = 3'b101,
    OP_ADDI = 3'b110,
    OP_SRAI = 3'b111
  } op_e;
  localparam logic [1:0] ALUOP_BR = 2'b00;
  localparam logic [1:0] ALUOP_LS = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;
  typedef enum logic {S_IDLE, S_MUL} state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-and-add multiplier retiring MUL_STEP multiplier bits per cycle
module alu_mul_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);
  localparam int N  = WIDTH / MUL_STEP;
  localparam int CW = $clog2(N + 1);
  logic [WIDTH-1:0] mcand, mplier, acc, digit, term;
  logic [CW-1:0]    count;
  // the multiplicand shifts left each step so the partial product lands at its weight
  assign digit     = WIDTH'(mplier[MUL_STEP-1:0]);
  assign term      = mcand * digit;
  assign done_o    = (count == CW'(1));
  assign product_o = acc + term;
  // latch operands on start, then accumulate one digit per cycle until count expires
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count  <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (clear_i) begin
      count <= '0;
    end else if (start_i) begin
      count  <= CW'(N);
      mcand  <= a_i;
      mplier <= b_i;
      acc    <= '0;
    end else if (count != '0) begin
      count  <= count - CW'(1);
      mcand  <= mcand << MUL_STEP;
      mplier <= mplier >> MUL_STEP;
      acc    <= acc + term;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execute stage with decode, registered result and iterative MUL
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       ALUOp_i,
  input  logic [6:0]       funct7_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             busy_o
);
  localparam int SHW = $clog2(WIDTH);
  state_e           state;
  op_e              op;
  logic             legal, accept, is_mul, mul_done;
  logic [WIDTH-1:0] alu_res, product;
  logic [SHW-1:0]   shamt;
  assign shamt   = b_i[SHW-1:0];
  assign ready_o = (state == S_IDLE) && (!valid_o || ready_i) && !flush_i;
  assign accept  = valid_i && ready_o;
  assign is_mul  = legal && (op == OP_MUL);
  assign busy_o  = (state == S_MUL);
  assign zero_o  = (result_o == '0);
  // decode ALUOp/funct7/funct3 into an internal op; anything unlisted is illegal
  always_comb begin
    op    = OP_ADD;
    legal = 1'b1;
    case (ALUOp_i)
      ALUOP_BR: op = OP_SUB;
      ALUOP_LS: op = OP_ADD;
      ALUOP_R: begin
        case ({funct7_i, funct3_i})
          10'b0000000_111: op = OP_AND;
          10'b0000000_100: op = OP_XOR;
          10'b0000000_001: op = OP_SLL;
          10'b0000000_000: op = OP_ADD;
          10'b0100000_000: op = OP_SUB;
          10'b0000001_000: op = OP_MUL;
          default:         legal = 1'b0;
        endcase
      end
      default: begin
        case (funct3_i)
          3'b000:  op = OP_ADDI;
          3'b101:  op = OP_SRAI;
          default: legal = 1'b0;
        endcase
      end
    endcase
  end
  // single-cycle datapath; MUL is produced by the iterative unit instead
  always_comb begin
    alu_res = '0;
    case (op)
      OP_AND:  alu_res = a_i & b_i;
      OP_XOR:  alu_res = a_i ^ b_i;
      OP_SLL:  alu_res = a_i << shamt;
      OP_SUB:  alu_res = a_i - b_i;
      OP_SRAI: alu_res = $signed(a_i) >>> shamt;
      OP_MUL:  alu_res = '0;
      default: alu_res = a_i + b_i;
    endcase
  end
  alu_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (flush_i),
    .start_i  (accept && is_mul),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (mul_done),
    .product_o(product)
  );
  // IDLE accepts; a MUL request parks the unit in MUL until the multiplier finishes
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else if (flush_i) state <= S_IDLE;
    else if (state == S_IDLE && accept && is_mul) state <= S_MUL;
    else if (state == S_MUL && mul_done) state <= S_IDLE;
  end
  // single-entry output register: holds under backpressure, reloads on the draining edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (state == S_MUL && mul_done) begin
      valid_o   <= 1'b1;
      result_o  <= product;
      illegal_o <= 1'b0;
    end else if (accept && !is_mul) begin
      valid_o   <= 1'b1;
      result_o  <= legal ? alu_res : '0;
      illegal_o <= !legal;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised, handshaked ALU execute stage that combines operation decode (ALUOp/funct7/funct3 → ALU operation) with a registered datapath and an iterative multiplier. It sits between the ID/EX pipeline register and the EX/MEM register of the lab CPU. Single-cycle ops complete in one cycle; MUL runs over multiple cycles behind a valid/ready handshake, with flush and backpressure support.

## Interface
- WIDTH, 32, datapath width; power of two, ≥ 8
- MUL_STEP, 1, multiplier bits retired per cycle; power of two, divides WIDTH
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  asynchronous, active-low reset
- flush_i  in  1  synchronous abort of in-flight op and output
- valid_i  in  1  request valid
- ready_o  out  1  unit can accept a request this cycle
- ALUOp_i  in  2  00 branch, 01 load/store, 10 R-type, 11 I-type
- funct7_i  in  7  instruction funct7
- funct3_i  in  3  instruction funct3
- a_i  in  WIDTH  operand rs1
- b_i  in  WIDTH  operand rs2 or sign-extended immediate
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- result_o  out  WIDTH  result
- zero_o  out  1  result_o == 0
- illegal_o  out  1  request decoded to no legal op
- busy_o  out  1  multiplier running

## Operation
- Decode: 00→SUB; 01→ADD; 10: {f7,f3} 0000000_111 AND, 0000000_100 XOR, 0000000_001 SLL, 0000000_000 ADD, 0100000_000 SUB, 0000001_000 MUL; 11: f3 000 ADDI, 101 SRAI; all other combinations illegal.
- Arithmetic modulo 2^WIDTH; MUL returns low WIDTH bits of the product, signed and unsigned interpretations identical.
- SLL/SRAI shift by b_i[$clog2(WIDTH)-1:0]; SRAI replicates a_i MSB. ADDI adds b_i as given.
- Illegal: completes in one cycle, result_o = 0, illegal_o = 1, no X on any output.
- FSM: IDLE, MUL. IDLE accepts; MUL accepted → MUL with count = WIDTH/MUL_STEP, multiplicand/multiplier/accumulator latched. Each MUL cycle adds (a · b[MUL_STEP-1:0]) << shift to accumulator, shifts multiplier right by MUL_STEP, decrements count; when count reaches 1, accumulator written to output register, valid_o set, → IDLE.
- Output register single-entry; result_o, zero_o, illegal_o stable while valid_o && !ready_i.
- ready_o = (state == IDLE) && (!valid_o || ready_i) && !flush_i.
- flush_i: clears valid_o, forces IDLE, drops request presented that cycle; flush wins over every other event.

## Timing
- Reset: valid_o 0, ready_o 1 once rst_n_i high, result_o 0, zero_o 1, illegal_o 0, busy_o 0, FSM IDLE, count 0.
- Reset asserted mid-MUL: immediate abort, all outputs to reset values; no result emitted after release.
- Non-MUL latency: accept at edge k → valid_o high after edge k.
- MUL latency: accept at edge k → busy_o high after k through k+N-1, valid_o high after edge k+N, N = WIDTH/MUL_STEP (32 at defaults).
- Throughput: one single-cycle op per cycle while ready_i high; back-to-back accept allowed in the cycle the output drains.
- ready_o low throughout MUL and while output held under backpressure.
- Output drain and new accept on the same edge: old result handed off, new result loaded.

## Structure
- Shared package alu_pkg: 3-bit op encoding (AND 000, XOR 001, SLL 010, ADD 011, SUB 100, MUL 101, ADDI 110, SRAI 111), ALUOp codes, FSM state type.
- Sub-module alu_mul_iter: iterative multiplier (start, operands, done, product), parametrised WIDTH/MUL_STEP; decode and single-cycle datapath stay in top.

## Test plan
- Reset then R-type 0000000_000, a=5, b=5 → next cycle valid_o=1, result_o=0x0000000A, zero_o=0; ALUOp 00 same operands → result 0, zero_o=1.
- MUL 0000001_000, a=7, b=0xFFFFFFFD, defaults → busy_o 32 cycles, ready_o low throughout, result_o=0xFFFFFFEB; repeat with MUL_STEP=4 → 8 cycles, same result.
- I-type f3 101, a=0x80000000, b=4 → 0xF8000000; f3 000, a=1, b=0xFFFFFFFF → 0.
- Illegal {0100000,111} → illegal_o=1, result_o=0, one-cycle latency; next legal op clears illegal_o.
- ready_i low 5 cycles with valid_o high → result_o/zero_o stable, ready_o low; ready_i high → handoff and new accept same edge.
- flush_i at MUL cycle 10, and separately rst_n_i low at cycle 10 → no valid_o, IDLE next cycle, following ADD 2+3 returns 5.
